// File: rtl/ysyx_25020047_ifq.sv
// Instruction fetch queue between IFU and IDU: in-order circular buffer of
// (pc, inst, misalign) entries with valid/ready on both sides and a one-cycle flush.
module ysyx_25020047_ifq #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_misalign,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   inst_d [DEPTH];
  logic          mis_q  [DEPTH];
  logic          mis_d  [DEPTH];
  logic          enq, deq;

  // Ready/valid come from the count register only, so neither side sees a
  // combinational path from the other.
  assign in_ready  = (count_q != CW'(DEPTH)) & ~flush;
  assign out_valid = (count_q != '0) & ~flush;
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  assign out_pc       = pc_q[head_q];
  assign out_inst     = inst_q[head_q];
  assign out_misalign = mis_q[head_q];
  assign count        = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    mis_d   = mis_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        pc_d[tail_q]   = in_pc;
        inst_d[tail_q] = in_inst;
        mis_d[tail_q]  = |in_pc[1:0];
        tail_d         = tail_q + AW'(1);
      end
      if (deq) head_d = head_q + AW'(1);
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (deq && !enq) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
        mis_q[i]  <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      mis_q   <= mis_d;
    end
  end
endmodule

// File: tb/tb_ysyx_25020047_ifq.sv
// Bench for ysyx_25020047_ifq: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_ysyx_25020047_ifq;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_misalign;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [2:0]  count;

  ysyx_25020047_ifq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_misalign(out_misalign), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t model_q[$];
  int   tests = 0;
  int   fails = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of accepted entries.
  always @(posedge clk) begin
    if (rst || flush) model_q.delete();
    else begin
      bit can_enq, can_deq;
      ent_t e;
      can_enq = in_valid && (model_q.size() < DEPTH);
      can_deq = out_ready && (model_q.size() > 0);
      if (can_deq) void'(model_q.pop_front());
      if (can_enq) begin
        e.pc = in_pc; e.inst = in_inst;
        model_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = model_q.size();
      chk("count", 64'(count), 64'(n));
      chk("in_ready", 64'(in_ready), 64'((n != DEPTH) && !flush));
      chk("out_valid", 64'(out_valid), 64'((n != 0) && !flush));
      if (n != 0 && !flush) begin
        chk("out_pc", 64'(out_pc), 64'(model_q[0].pc));
        chk("out_inst", 64'(out_inst), 64'(model_q[0].inst));
        chk("out_misalign", 64'(out_misalign), 64'(model_q[0].pc[1:0] != 2'b00));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    tick(); tick();
    rst = 1'b0; chk_en = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_mis", 64'(out_misalign), 64'd0);

    // single entry, one-cycle latency
    tick();
    in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'h0000_0413;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_pc", 64'(out_pc), 64'h8000_0000);
    chk("single_inst", 64'(out_inst), 64'h0000_0413);
    chk("single_count", 64'(count), 64'd1);
    chk("single_mis", 64'(out_misalign), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // fill to full, fifth offer rejected, drain in order
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h8000_0000 + 32'(4 * i); in_inst = 32'h100 + 32'(i);
      tick();
    end
    in_pc = 32'h8000_0010; in_inst = 32'h104;
    @(negedge clk);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_pc", 64'(out_pc), 64'h8000_0000 + 64'(4 * i));
      tick();
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("drain_empty", 64'(out_valid), 64'd0);
    tick();

    // streaming across pointer wrap
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_pc = 32'h8000_0000 + 32'(4 * i); in_inst = 32'h200 + 32'(i);
      if (i > 0) begin
        @(negedge clk);
        chk("stream_count", 64'(count), 64'd1);
        chk("stream_pc", 64'(out_pc), 64'h8000_0000 + 64'(4 * (i - 1)));
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;

    // flush with simultaneous traffic
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h8000_0200 + 32'(4 * i); in_inst = 32'h300 + 32'(i);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h8000_0100; in_inst = 32'h399; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_count_before", 64'(count), 64'd3);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("flush_count_after", 64'(count), 64'd0);
    chk("flush_empty", 64'(out_valid), 64'd0);
    tick();

    // misaligned pc
    in_valid = 1'b1; in_pc = 32'h8000_0002; in_inst = 32'hdead_beef;
    tick();
    in_pc = 32'h8000_0004; in_inst = 32'h0000_0013; out_ready = 1'b1;
    @(negedge clk);
    chk("mis_flag", 64'(out_misalign), 64'd1);
    chk("mis_inst", 64'(out_inst), 64'hdead_beef);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("aligned_flag", 64'(out_misalign), 64'd0);
    chk("aligned_pc", 64'(out_pc), 64'h8000_0004);
    tick();
    out_ready = 1'b0;

    // reset mid-operation
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'h8000_0400 + 32'(4 * i); in_inst = 32'h400 + 32'(i);
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    tick();

    // random backpressure
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_pc     = $urandom();
      in_inst   = $urandom();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
